enc8b10b_multilane: RTL and testbench

- Parametrised successor of the single-byte 8b/10b encoder.
- Encodes NBYTES bytes per clock with full control-character (K) support. Running disparity is chained lane 0 to lane NBYTES-1 within a word and carried across words.
- Valid/ready streaming on both sides, plus K-code error detection and counting.
- Sits between the framing/idle-insertion logic and the serialiser.

---
 rtl/enc8b10b_pkg.sv | 28 ++
 rtl/enc8b10b_lane.sv | 149 ++++++++++++++
 rtl/enc8b10b_multilane.sv | 92 +++++++++
 tb/tb_enc8b10b_multilane.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/enc8b10b_pkg.sv
// enc8b10b_pkg
//   Shared constants and helpers for the multi-lane 8b/10b encoder.
//   CODE_W      : width of one encoded symbol (10).
//   K28_0..K30_7: byte values of the valid control characters.
//   is_valid_k  : returns 1 when a byte is one of the twelve legal K codes.
package enc8b10b_pkg;

    localparam int CODE_W = 10;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    function automatic logic is_valid_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == K23_7) || (b == K27_7) ||
               (b == K29_7) || (b == K30_7);
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// enc8b10b_lane
//   Combinational 8b/10b encoder for one byte.
//   din[7:0]  : byte HGFEDCBA (EDCBA = din[4:0]).
//   k         : control-character request.
//   rd_in     : running disparity entering this symbol (0 = RD-, 1 = RD+).
//   code[9:0] : abcdei fghj, a = bit 9.
//   rd_out    : running disparity after this symbol.
//   kerr      : k requested for a byte that is not a legal K code.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [7:0]        din,
    input  logic              k,
    input  logic              rd_in,
    output logic [CODE_W-1:0] code,
    output logic              rd_out,
    output logic              kerr
);

    // RD- form of the 5b/6b table (abcdei). The RD+ form is the complement
    // for every unbalanced entry and for D.7.
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        logic [5:0] r;
        case (x)
            5'd0:  r = 6'b100111;
            5'd1:  r = 6'b011101;
            5'd2:  r = 6'b101101;
            5'd3:  r = 6'b110001;
            5'd4:  r = 6'b110101;
            5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;
            5'd7:  r = 6'b111000;
            5'd8:  r = 6'b111001;
            5'd9:  r = 6'b100101;
            5'd10: r = 6'b010101;
            5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;
            5'd13: r = 6'b101100;
            5'd14: r = 6'b011100;
            5'd15: r = 6'b010111;
            5'd16: r = 6'b011011;
            5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;
            5'd19: r = 6'b110010;
            5'd20: r = 6'b001011;
            5'd21: r = 6'b101010;
            5'd22: r = 6'b011010;
            5'd23: r = 6'b111010;
            5'd24: r = 6'b110011;
            5'd25: r = 6'b100110;
            5'd26: r = 6'b010110;
            5'd27: r = 6'b110110;
            5'd28: r = 6'b001110;
            5'd29: r = 6'b101110;
            5'd30: r = 6'b011110;
            default: r = 6'b101011;
        endcase
        return r;
    endfunction

    // RD- form of the data 3b/4b table (fghj); y=7 gives P7.
    function automatic logic [3:0] tbl4_d(input logic [2:0] y);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;
            3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;
            3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;
            3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;
            default: r = 4'b1110;
        endcase
        return r;
    endfunction

    // RD- form of the K28 3b/4b table; y=1,2,5,6 have inverted sense
    // relative to the data table.
    function automatic logic [3:0] tbl4_k(input logic [2:0] y);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;
            3'd1: r = 4'b0110;
            3'd2: r = 4'b1010;
            3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;
            3'd5: r = 4'b0101;
            3'd6: r = 4'b1001;
            default: r = 4'b0111;
        endcase
        return r;
    endfunction

    logic [4:0] x;
    logic [2:0] y;
    logic       kvalid;
    logic       k28;
    logic [5:0] six_n;
    logic [5:0] six;
    logic       rd6;
    logic       use_a7;
    logic [3:0] four_n;
    logic [3:0] four;
    int         ones6;
    int         ones4;

    always_comb begin
        x      = din[4:0];
        y      = din[7:5];
        kvalid = k && is_valid_k(din);
        kerr   = k && !is_valid_k(din);
        k28    = kvalid && (x == 5'd28);

        six_n = k28 ? 6'b001111 : tbl6(x);
        if (rd_in && (($countones(six_n) != 3) || (!k28 && x == 5'd7)))
            six = ~six_n;
        else
            six = six_n;

        ones6 = $countones(six);
        if (ones6 > 3)      rd6 = 1'b1;
        else if (ones6 < 3) rd6 = 1'b0;
        else                rd6 = rd_in;

        // A7 avoids a run of five identical bits across the sub-block boundary.
        use_a7 = (y == 3'd7) &&
                 (kvalid ||
                  (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                  ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

        if (use_a7)   four_n = 4'b0111;
        else if (k28) four_n = tbl4_k(y);
        else          four_n = tbl4_d(y);

        // Balanced K28 entries and D.x.3 still alternate with RD.
        if (rd6 && (k28 || ($countones(four_n) != 2) || (y == 3'd3)))
            four = ~four_n;
        else
            four = four_n;

        ones4 = $countones(four);
        if (ones4 > 2)      rd_out = 1'b1;
        else if (ones4 < 2) rd_out = 1'b0;
        else                rd_out = rd6;

        code = {six, four};
    end

endmodule

// File: rtl/enc8b10b_multilane.sv
// enc8b10b_multilane
//   NBYTES-wide 8b/10b encoder with valid/ready on both sides.
//   clk, rst          : clock, asynchronous active-high reset.
//   s_valid/s_ready   : input handshake; s_data bytes, s_k per-lane K flags.
//   m_valid/m_ready   : output handshake; m_data 10-bit codes, m_kerr flags.
//   rd                : running disparity after the last accepted word.
//   err_cnt / err_clr : saturating invalid-K lane counter and its clear.
module enc8b10b_multilane
    import enc8b10b_pkg::*;
#(
    parameter int NBYTES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [8*NBYTES-1:0]      s_data,
    input  logic [NBYTES-1:0]        s_k,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CODE_W*NBYTES-1:0] m_data,
    output logic [NBYTES-1:0]        m_kerr,
    output logic                     rd,
    output logic [ERR_CNT_W-1:0]     err_cnt,
    input  logic                     err_clr
);

    function automatic logic [3:0] popcount(input logic [NBYTES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NBYTES; i++)
            c = c + {3'd0, v[i]};
        return c;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [3:0]           b);
        logic [ERR_CNT_W+3:0] s;
        s = {4'd0, a} + {{ERR_CNT_W{1'b0}}, b};
        return (|s[ERR_CNT_W+3:ERR_CNT_W]) ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
    endfunction

    logic [NBYTES:0]              rd_chain_p0;
    logic [CODE_W*NBYTES-1:0]     code_p0;
    logic [NBYTES-1:0]            kerr_p0;
    logic                         accept_p0;

    // Stage p0: combinational lane chain, disparity ripples lane 0 upward.
    assign rd_chain_p0[0] = rd;

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        enc8b10b_lane u_lane (
            .din    (s_data[8*i +: 8]),
            .k      (s_k[i]),
            .rd_in  (rd_chain_p0[i]),
            .code   (code_p0[CODE_W*i +: CODE_W]),
            .rd_out (rd_chain_p0[i+1]),
            .kerr   (kerr_p0[i])
        );
    end

    assign s_ready   = !m_valid || m_ready;
    assign accept_p0 = s_valid && s_ready;

    // Stage p1: output register, disparity state and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_kerr  <= '0;
            rd      <= 1'b0;
        end else if (accept_p0) begin
            m_valid <= 1'b1;
            m_data  <= code_p0;
            m_kerr  <= kerr_p0;
            rd      <= rd_chain_p0[NBYTES];
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (accept_p0)
            err_cnt <= sat_add(err_cnt, popcount(kerr_p0));
    end

endmodule

// File: tb/tb_enc8b10b_multilane.sv
module tb_enc8b10b_multilane;

    typedef struct packed {
        logic [19:0] d;
        logic [1:0]  k;
        logic        r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic [1:0]  s_k = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [19:0] m_data;
    logic [1:0]  m_kerr;
    logic        rd;
    logic [7:0]  err_cnt;
    logic        err_clr = 1'b0;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    enc8b10b_multilane #(.NBYTES(2), .ERR_CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_k     (s_k),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_kerr  (m_kerr),
        .rd      (rd),
        .err_cnt (err_cnt),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    // Monitor: every transfer observed at the negedge before its clock edge.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word got=%h want=none", m_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_data", {12'd0, m_data}, {12'd0, e.d});
                check("m_kerr", {30'd0, m_kerr}, {30'd0, e.k});
                check("rd",     {31'd0, rd},     {31'd0, e.r});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=%0d want=accept", n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic issue(input logic [15:0] d, input logic [1:0] k,
                         input logic [19:0] ed, input logic [1:0] ek, input logic er);
        exp_t e;
        e.d = ed;
        e.k = ek;
        e.r = er;
        exp_q.push_back(e);
        s_data  = d;
        s_k     = k;
        s_valid = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k,
                        input logic [19:0] ed, input logic [1:0] ek, input logic er);
        issue(d, k, ed, ek, er);
        wait_accept();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data",  {12'd0, m_data},  32'd0);
        check("rst_m_kerr",  {30'd0, m_kerr},  32'd0);
        check("rst_rd",      {31'd0, rd},      32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b1;

        // K28.5 RD- then D21.5
        send(16'hB5BC, 2'b01, {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
        // D0.0 at RD+
        send(16'h0000, 2'b00, {10'h18B, 10'h18B}, 2'b00, 1'b1);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        // D0.0 at RD-
        send(16'h0000, 2'b00, {10'h274, 10'h274}, 2'b00, 1'b0);
        // D17.7 (A7 at RD-) then K28.5 at RD+
        send(16'hBCF1, 2'b10, {10'h305, 10'h237}, 2'b00, 1'b0);
        // K23.7 then D3.3
        send(16'h63F7, 2'b01, {10'h31C, 10'h3A8}, 2'b00, 1'b0);
        // D11.7: P7 at RD-, A7 at RD+
        send(16'hEBEB, 2'b00, {10'h348, 10'h34E}, 2'b00, 1'b0);
        // K28.1 at RD- then RD+
        send(16'h3C3C, 2'b11, {10'h306, 10'h0F9}, 2'b00, 1'b0);

        // Invalid K on both lanes, counter to saturation
        send(16'h0000, 2'b11, {10'h274, 10'h274}, 2'b11, 1'b0);
        check("err_cnt_2", {24'd0, err_cnt}, 32'd2);
        for (int i = 0; i < 126; i++)
            send(16'h0000, 2'b11, {10'h274, 10'h274}, 2'b11, 1'b0);
        check("err_cnt_254", {24'd0, err_cnt}, 32'd254);
        send(16'h0000, 2'b11, {10'h274, 10'h274}, 2'b11, 1'b0);
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        send(16'h0000, 2'b11, {10'h274, 10'h274}, 2'b11, 1'b0);
        check("err_cnt_hold", {24'd0, err_cnt}, 32'd255);
        err_clr = 1'b1;
        send(16'h0000, 2'b11, {10'h274, 10'h274}, 2'b11, 1'b0);
        err_clr = 1'b0;
        check("err_clr_prio", {24'd0, err_cnt}, 32'd0);

        // Backpressure
        idle(2);
        m_ready = 1'b0;
        send(16'hB5BC, 2'b01, {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
        issue(16'h0000, 2'b00, {10'h18B, 10'h18B}, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_s_ready", {31'd0, s_ready}, 32'd0);
            check("bp_m_valid", {31'd0, m_valid}, 32'd1);
            check("bp_m_data",  {12'd0, m_data},  {12'd0, 10'h2AA, 10'h0FA});
            check("bp_rd",      {31'd0, rd},      32'd1);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_accept();
        idle(2);

        // Asynchronous reset with a held word in flight
        m_ready = 1'b0;
        send(16'h0000, 2'b11, {10'h18B, 10'h18B}, 2'b11, 1'b1);
        check("pre_rst_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("pre_rst_rd", {31'd0, rd}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_m_data",  {12'd0, m_data},  32'd0);
        check("arst_m_kerr",  {30'd0, m_kerr},  32'd0);
        check("arst_rd",      {31'd0, rd},      32'd0);
        check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        if (exp_q.size() > 0)
            void'(exp_q.pop_back());
        @(posedge clk);
        #2 rst = 1'b0;
        m_ready = 1'b1;
        idle(1);
        send(16'h0000, 2'b00, {10'h274, 10'h274}, 2'b00, 1'b0);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
